// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: drives a req/ack data port, places store lanes and formats load data.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (BusErrM_o tied low otherwise).
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic [2:0]            Funct3M_i,
    input  logic [ADDR_WIDTH-1:0] ALUResultM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    output logic [DATA_WIDTH-1:0] ReadDataM_o,
    output logic                  StallM_o,
    output logic                  MisalignM_o,
    output logic                  BusErrM_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [DATA_WIDTH-1:0] format_load(input logic [2:0]            f3,
                                                           input logic [1:0]            lo,
                                                           input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] sh;
        logic signed [7:0]     sb;
        logic signed [15:0]    shw;
        sh  = word >> {lo, 3'b000};
        sb  = sh[7:0];
        shw = sh[15:0];
        case (f3)
            3'b000:  format_load = DATA_WIDTH'(sb);
            3'b001:  format_load = DATA_WIDTH'(shw);
            3'b100:  format_load = DATA_WIDTH'(sh[7:0]);
            3'b101:  format_load = DATA_WIDTH'(sh[15:0]);
            default: format_load = word;
        endcase
    endfunction

    logic [1:0]            state_d, state_q;
    logic                  req_d, req_q;
    logic                  we_d, we_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [3:0]            be_d, be_q;
    logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
    logic [2:0]            f3_d, f3_q;
    logic [1:0]            lo_d, lo_q;
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    logic                  is_load, is_store, access, misalign, stall;
    logic                  align_err, f3_illegal;
    logic [1:0]            addr_lo;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;

    // Decode: a simultaneous read+write is treated as a write.
    always_comb begin
        is_store   = MemWriteM_i;
        is_load    = MemReadM_i & ~MemWriteM_i;
        addr_lo    = ALUResultM_i[1:0];
        align_err  = 1'b0;
        lane_be    = 4'b1111;
        lane_wdata = WriteDataM_i;
        case (Funct3M_i[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << addr_lo;
                lane_wdata = {4{WriteDataM_i[7:0]}};
            end
            2'b01: begin
                align_err  = addr_lo[0];
                lane_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{WriteDataM_i[15:0]}};
            end
            2'b10: begin
                align_err  = |addr_lo;
            end
            default: begin
                align_err  = 1'b0;
            end
        endcase
        f3_illegal = is_store ? (Funct3M_i >= 3'b011)
                              : ((Funct3M_i == 3'b011) || (Funct3M_i[2:1] == 2'b11));
        misalign   = (is_store | is_load) & (align_err | f3_illegal);
        access     = (is_store | is_load) & ~misalign;
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             timeout;
    logic             buserr_d, buserr_q;

    // Counts BUSY cycles without ack; fires on the last allowed cycle so BUSY lasts TIMEOUT_CYCLES.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if ((state_q == S_BUSY) && !mem_ack_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == S_BUSY) && !mem_ack_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
        end
    end

    assign BusErrM_o = buserr_q;
`else
    assign BusErrM_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        stall   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        buserr_d = buserr_q;
`endif
        case (state_q)
            S_IDLE: begin
                stall = access;
                if (access) begin
                    state_d = S_BUSY;
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {ALUResultM_i[ADDR_WIDTH-1:2], 2'b00};
                    be_d    = lane_be;
                    wdata_d = lane_wdata;
                    f3_d    = Funct3M_i;
                    lo_d    = addr_lo;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (!we_q) begin
                        rdata_d = format_load(f3_q, lo_q, mem_rdata_i);
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    req_d    = 1'b0;
                    buserr_d = 1'b1;
                    state_d  = S_DONE;
                    if (!we_q) begin
                        rdata_d = '0;
                    end
                end
`endif
            end
            // One unstalled cycle lets pip_reg_w capture the result; never re-issues.
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    assign StallM_o    = stall & rst_ni;
    assign MisalignM_o = misalign;
    assign ReadDataM_o = rdata_q;
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expectations, a monitor checks each completion.
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        MemReadM_i = 1'b0;
    logic        MemWriteM_i = 1'b0;
    logic [2:0]  Funct3M_i = 3'b000;
    logic [31:0] ALUResultM_i = 32'h0;
    logic [31:0] WriteDataM_i = 32'h0;
    logic [31:0] ReadDataM_o;
    logic        StallM_o;
    logic        MisalignM_o;
    logic        BusErrM_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    always #5 clk_i = ~clk_i;

    mem_access_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .MemReadM_i(MemReadM_i),
        .MemWriteM_i(MemWriteM_i),
        .Funct3M_i(Funct3M_i),
        .ALUResultM_i(ALUResultM_i),
        .WriteDataM_i(WriteDataM_i),
        .ReadDataM_o(ReadDataM_o),
        .StallM_o(StallM_o),
        .MisalignM_o(MisalignM_o),
        .BusErrM_o(BusErrM_o),
        .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          nreq;
        int          nstall;
        logic        buserr;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: capture request fields on the first req cycle, count req/stall cycles, compare at the DONE cycle.
    logic        stall_prev = 1'b0;
    logic        req_prev = 1'b0;
    int          req_cnt = 0;
    int          stall_cnt = 0;
    logic        cap_we = 1'b0;
    logic [31:0] cap_addr = 32'h0;
    logic [3:0]  cap_be = 4'h0;
    logic [31:0] cap_wdata = 32'h0;
    exp_t        mon_e;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            stall_prev = 1'b0;
            req_prev   = 1'b0;
            req_cnt    = 0;
            stall_cnt  = 0;
        end else begin
            if (mem_req_o && !req_prev) begin
                cap_we    = mem_we_o;
                cap_addr  = mem_addr_o;
                cap_be    = mem_be_o;
                cap_wdata = mem_wdata_o;
            end
            if (mem_req_o) req_cnt++;
            if (StallM_o) stall_cnt++;
            if (stall_prev && !StallM_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("req_we", 32'(cap_we), 32'(mon_e.we));
                    check("req_addr", cap_addr, mon_e.addr);
                    check("req_be", 32'(cap_be), 32'(mon_e.be));
                    check("req_wdata", cap_wdata, mon_e.wdata);
                    check("req_cycles", 32'(req_cnt), 32'(mon_e.nreq));
                    check("stall_cycles", 32'(stall_cnt), 32'(mon_e.nstall));
                    check("read_data", ReadDataM_o, mon_e.rdata);
                    check("bus_err", 32'(BusErrM_o), 32'(mon_e.buserr));
                end
                req_cnt   = 0;
                stall_cnt = 0;
            end
            stall_prev = StallM_o;
            req_prev   = mem_req_o;
        end
    end

    task automatic go_idle();
        MemReadM_i  = 1'b0;
        MemWriteM_i = 1'b0;
        Funct3M_i   = 3'b000;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int nbusy, input logic ack, input logic [31:0] rdata,
                             input logic [31:0] e_addr, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_rd, input logic e_err);
        exp_t e;
        e.we     = wr;
        e.addr   = e_addr;
        e.be     = e_be;
        e.wdata  = e_wdata;
        e.rdata  = e_rd;
        e.nreq   = nbusy;
        e.nstall = nbusy + 1;
        e.buserr = e_err;
        sb_q.push_back(e);
        MemReadM_i   = rd;
        MemWriteM_i  = wr;
        Funct3M_i    = f3;
        ALUResultM_i = addr;
        WriteDataM_i = wd;
        @(posedge clk_i); #1;
        for (int i = 1; i < nbusy; i++) begin
            @(posedge clk_i); #1;
        end
        if (ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = rdata;
        end
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        go_idle();
        @(posedge clk_i); #1;
    endtask

    task automatic misalign_case(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] keep);
        MemReadM_i   = rd;
        MemWriteM_i  = wr;
        Funct3M_i    = f3;
        ALUResultM_i = addr;
        #1;
        check({name, "_misalign"}, 32'(MisalignM_o), 32'd1);
        check({name, "_stall"}, 32'(StallM_o), 32'd0);
        @(posedge clk_i); #1;
        check({name, "_req"}, 32'(mem_req_o), 32'd0);
        check({name, "_rdata"}, ReadDataM_o, keep);
        go_idle();
        @(posedge clk_i); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Access presented while reset is held must not stall.
        rst_ni       = 1'b0;
        MemReadM_i   = 1'b1;
        Funct3M_i    = 3'b010;
        ALUResultM_i = 32'h100;
        #1;
        check("rst_stall_held", 32'(StallM_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_rdata", ReadDataM_o, 32'h0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("rst_buserr", 32'(BusErrM_o), 32'd0);
        go_idle();
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        //          rd    wr    f3      addr        wd            nb ack rdata          e_addr      e_be     e_wdata       e_rd          err
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        3, 1'b1, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0);
        do_access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0,        1, 1'b1, 32'h80AABBCC, 32'h200, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0);
        do_access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0,        1, 1'b1, 32'h80AABBCC, 32'h200, 4'b1000, 32'h0,        32'h00000080, 1'b0);
        do_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0,        2, 1'b1, 32'h80AABBCC, 32'h200, 4'b1100, 32'h0,        32'hFFFF80AA, 1'b0);
        do_access(1'b1, 1'b0, 3'b101, 32'h200, 32'h0,        1, 1'b1, 32'h80AABBCC, 32'h200, 4'b0011, 32'h0,        32'h0000BBCC, 1'b0);
        do_access(1'b1, 1'b0, 3'b000, 32'h001, 32'h0,        1, 1'b1, 32'h00007F00, 32'h000, 4'b0010, 32'h0,        32'h0000007F, 1'b0);
        do_access(1'b0, 1'b1, 3'b000, 32'h001, 32'h12345678, 2, 1'b1, 32'hFFFFFFFF, 32'h000, 4'b0010, 32'h78787878, 32'h0000007F, 1'b0);
        do_access(1'b0, 1'b1, 3'b001, 32'h006, 32'h12345678, 1, 1'b1, 32'hFFFFFFFF, 32'h004, 4'b1100, 32'h56785678, 32'h0000007F, 1'b0);
        do_access(1'b0, 1'b1, 3'b010, 32'h008, 32'hCAFEF00D, 1, 1'b1, 32'hFFFFFFFF, 32'h008, 4'b1111, 32'hCAFEF00D, 32'h0000007F, 1'b0);
        do_access(1'b1, 1'b1, 3'b010, 32'h00C, 32'h0BADF00D, 1, 1'b1, 32'hFFFFFFFF, 32'h00C, 4'b1111, 32'h0BADF00D, 32'h0000007F, 1'b0);

        misalign_case("lw_0x102", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0000007F);
        misalign_case("lh_0x201", 1'b1, 1'b0, 3'b001, 32'h201, 32'h0000007F);
        misalign_case("ld_f3_110", 1'b1, 1'b0, 3'b110, 32'h200, 32'h0000007F);
        misalign_case("st_f3_011", 1'b0, 1'b1, 3'b011, 32'h200, 32'h0000007F);
        misalign_case("st_f3_100", 1'b0, 1'b1, 3'b100, 32'h200, 32'h0000007F);

        // Ack while idle is ignored.
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h55555555;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        check("idle_ack_req", 32'(mem_req_o), 32'd0);
        check("idle_ack_stall", 32'(StallM_o), 32'd0);
        check("idle_ack_rdata", ReadDataM_o, 32'h0000007F);

        // Reset during BUSY, followed by a late ack.
        MemReadM_i   = 1'b1;
        Funct3M_i    = 3'b010;
        ALUResultM_i = 32'h100;
        @(posedge clk_i); #1;
        check("midrst_busy_req", 32'(mem_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("midrst_stall", 32'(StallM_o), 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        go_idle();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h12345678;
        check("midrst_req_cleared", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        check("late_ack_req", 32'(mem_req_o), 32'd0);
        check("late_ack_stall", 32'(StallM_o), 32'd0);
        check("late_ack_rdata", ReadDataM_o, 32'h0);
        @(posedge clk_i); #1;
        check("late_ack_rdata_hold", ReadDataM_o, 32'h0);

`ifdef MEM_TIMEOUT_EN
        do_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1, 1'b1, 32'h11112222, 32'h400, 4'b1111, 32'h0, 32'h11112222, 1'b0);
        do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 4, 1'b0, 32'h0,        32'h300, 4'b1111, 32'h0, 32'h00000000, 1'b1);
        check("buserr_sticky", 32'(BusErrM_o), 32'd1);
        do_access(1'b1, 1'b0, 3'b100, 32'h000, 32'h0, 1, 1'b1, 32'h000000AB, 32'h000, 4'b0001, 32'h0, 32'h000000AB, 1'b1);
`endif

        repeat (3) @(posedge clk_i);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
